// File: rtl/ysyx_22050710_lsu_store.sv
// ============================================================================
// ysyx_22050710_lsu_store
// ----------------------------------------------------------------------------
// Store-side LSU in the MEM stage. This is the write-direction counterpart of
// the load align/extend path. It latches one store request and turns it into
// an 8-byte-aligned SRAM address, lane-shifted write data and a byte strobe.
// It then drives the data SRAM write port with a hold-until-ready handshake.
// o_ready is low from acceptance until the store completes, which stalls the
// pipeline.
//
// Configuration macro: YSYX_22050710_MISALIGN_STORE_EN
//   defined   : a store that crosses an 8-byte boundary is split into two
//               beats (BEAT0 for the low word, BEAT1 for the next word).
//               o_misalign is tied 0.
//   undefined : a crossing store is accepted but never written. o_misalign
//               pulses for one cycle instead, and no o_done is produced.
//               The BEAT1 logic is not built.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_mem_wen           store request valid
//   o_ready             unit idle; a request with i_mem_wen is taken this cycle
//   i_mem_op            size = op[2:1] (sb/sh/sw/sd); op[0] is ignored
//   i_waddr, i_wdata    store byte address, LSB-justified store data
//   o_data_sram_wen     SRAM write valid
//   i_data_sram_wready  SRAM accepts the write when high together with wen
//   o_data_sram_waddr   aligned word address, bits [2:0] always 0
//   o_data_sram_wdata   lane-shifted write data
//   o_data_sram_wmask   byte strobe; bit k enables byte lane k
//   o_done              1-cycle pulse after the final beat is written
//   o_misalign          1-cycle pulse when a crossing store is rejected
// ============================================================================
module ysyx_22050710_lsu_store #(
   parameter int WORD_WD      = 64,
   parameter int SRAM_DATA_WD = 64,
   parameter int ADDR_WD      = 64
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_mem_wen,
   output logic                      o_ready,
   input  logic [2:0]                i_mem_op,
   input  logic [ADDR_WD-1:0]        i_waddr,
   input  logic [WORD_WD-1:0]        i_wdata,
   output logic                      o_data_sram_wen,
   input  logic                      i_data_sram_wready,
   output logic [ADDR_WD-1:0]        o_data_sram_waddr,
   output logic [SRAM_DATA_WD-1:0]   o_data_sram_wdata,
   output logic [SRAM_DATA_WD/8-1:0] o_data_sram_wmask,
   output logic                      o_done,
   output logic                      o_misalign
);

   localparam int STRB_WD = SRAM_DATA_WD / 8;
   localparam int EXT_WD  = 2 * SRAM_DATA_WD;
   localparam int BASE_WD = ADDR_WD - 3;

`ifdef YSYX_22050710_MISALIGN_STORE_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BEAT0 = 2'd1,
      S_BEAT1 = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BEAT0 = 2'd1
   } state_t;
`endif

   // -------------------------------------------------------------------------
   // Size / lane helpers
   // -------------------------------------------------------------------------
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

   // The store spills into the next 8-byte word when off + nbytes > 8.
   function automatic logic cross_f(input logic [1:0] size, input logic [2:0] off);
      logic [3:0] sum;
      sum = {1'b0, off} + size_bytes(size);
      return sum > 4'd8;
   endfunction

   // (1 << nbytes) - 1, held in a double-width field so it can shift out of the word.
   function automatic logic [2*STRB_WD-1:0] size_mask(input logic [1:0] size);
      logic [2*STRB_WD-1:0] m;
      m = '0;
      case (size)
         2'd0:    m[0:0] = '1;
         2'd1:    m[1:0] = '1;
         2'd2:    m[3:0] = '1;
         default: m[7:0] = '1;
      endcase
      return m;
   endfunction

   function automatic logic [STRB_WD-1:0] beat0_mask(input logic [1:0] size,
                                                     input logic [2:0] off);
      logic [2*STRB_WD-1:0] sh;
      sh = size_mask(size) << off;
      return sh[STRB_WD-1:0];
   endfunction

   function automatic logic [SRAM_DATA_WD-1:0] beat0_data(input logic [WORD_WD-1:0] d,
                                                          input logic [2:0]         off);
      logic [EXT_WD-1:0] ext;
      ext = EXT_WD'(d) << {off, 3'b000};
      return ext[SRAM_DATA_WD-1:0];
   endfunction

`ifdef YSYX_22050710_MISALIGN_STORE_EN
   // The second beat carries the bytes that spilled past lane 7.
   function automatic logic [STRB_WD-1:0] beat1_mask(input logic [1:0] size,
                                                     input logic [2:0] off);
      logic [2*STRB_WD-1:0] sh;
      sh = size_mask(size) >> (4'd8 - {1'b0, off});
      return sh[STRB_WD-1:0];
   endfunction

   function automatic logic [SRAM_DATA_WD-1:0] beat1_data(input logic [WORD_WD-1:0] d,
                                                          input logic [2:0]         off);
      logic [EXT_WD-1:0] ext;
      ext = EXT_WD'(d) >> (7'd64 - {1'b0, off, 3'b000});
      return ext[SRAM_DATA_WD-1:0];
   endfunction
`endif

   // -------------------------------------------------------------------------
   // State and latched request
   // -------------------------------------------------------------------------
   state_t               state_q;
   state_t               state_d;
   logic                 accept;
   logic                 done_d;
   logic                 done_p1;
   logic [BASE_WD-1:0]   req_base_p0;
   logic [2:0]           req_off_p0;
   logic [1:0]           req_size_p0;
   logic [WORD_WD-1:0]   req_data_p0;

   logic                 unused_op0;
   assign unused_op0 = i_mem_op[0];

`ifdef YSYX_22050710_MISALIGN_STORE_EN
   logic                 req_cross;
   assign req_cross = cross_f(req_size_p0, req_off_p0);
`else
   logic                 in_cross;
   logic                 misalign_d;
   logic                 misalign_p1;
   assign in_cross = cross_f(i_mem_op[2:1], i_waddr[2:0]);
`endif

   assign o_ready = (state_q == S_IDLE);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      done_d  = 1'b0;
`ifndef YSYX_22050710_MISALIGN_STORE_EN
      misalign_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_mem_wen) begin
`ifdef YSYX_22050710_MISALIGN_STORE_EN
               accept  = 1'b1;
               state_d = S_BEAT0;
`else
               // Crossing stores cannot be written in this build; flag and drop.
               if (in_cross) begin
                  misalign_d = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = S_BEAT0;
               end
`endif
            end
         end
         S_BEAT0: begin
            if (i_data_sram_wready) begin
`ifdef YSYX_22050710_MISALIGN_STORE_EN
               if (req_cross) begin
                  state_d = S_BEAT1;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
`else
               state_d = S_IDLE;
               done_d  = 1'b1;
`endif
            end
         end
`ifdef YSYX_22050710_MISALIGN_STORE_EN
         S_BEAT1: begin
            if (i_data_sram_wready) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers. Reset aborts any store in flight, so the pending done pulse
   // and the latched request are cleared along with the state.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         done_p1     <= 1'b0;
         req_base_p0 <= '0;
         req_off_p0  <= '0;
         req_size_p0 <= '0;
         req_data_p0 <= '0;
      end else begin
         state_q <= state_d;
         done_p1 <= done_d;
         if (accept) begin
            req_base_p0 <= i_waddr[ADDR_WD-1:3];
            req_off_p0  <= i_waddr[2:0];
            req_size_p0 <= i_mem_op[2:1];
            req_data_p0 <= i_wdata;
         end
      end
   end

`ifndef YSYX_22050710_MISALIGN_STORE_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         misalign_p1 <= 1'b0;
      end else begin
         misalign_p1 <= misalign_d;
      end
   end
`endif

   // -------------------------------------------------------------------------
   // SRAM write port: driven only from registered state, so there is no
   // combinational path from the pipeline inputs to the SRAM.
   // -------------------------------------------------------------------------
   always_comb begin
      o_data_sram_wen   = 1'b0;
      o_data_sram_waddr = '0;
      o_data_sram_wdata = '0;
      o_data_sram_wmask = '0;
      case (state_q)
         S_BEAT0: begin
            o_data_sram_wen   = 1'b1;
            o_data_sram_waddr = {req_base_p0, 3'b000};
            o_data_sram_wdata = beat0_data(req_data_p0, req_off_p0);
            o_data_sram_wmask = beat0_mask(req_size_p0, req_off_p0);
         end
`ifdef YSYX_22050710_MISALIGN_STORE_EN
         S_BEAT1: begin
            o_data_sram_wen   = 1'b1;
            // Next word; wraps at the top of the address space.
            o_data_sram_waddr = {req_base_p0 + BASE_WD'(1), 3'b000};
            o_data_sram_wdata = beat1_data(req_data_p0, req_off_p0);
            o_data_sram_wmask = beat1_mask(req_size_p0, req_off_p0);
         end
`endif
         default: ;
      endcase
   end

   assign o_done = done_p1;

`ifdef YSYX_22050710_MISALIGN_STORE_EN
   assign o_misalign = 1'b0;
`else
   assign o_misalign = misalign_p1;
`endif

endmodule
